hazard_forward_unit: RTL and testbench

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

---
 rtl/hazard_forward_unit_pkg.sv | 33 +++
 rtl/hazard_forward_unit_stall_counter16.sv | 20 ++
 rtl/hazard_forward_unit.sv | 82 ++++++++
 tb/tb_hazard_forward_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and encodings for the EX-stage forwarding / load-use unit.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } stage_t;

    function automatic logic [1:0] fwd_sel(
        input stage_t     mem,
        input stage_t     wb,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem.reg_write && (mem.dest != 5'd0) && (mem.dest == src))
            sel = FWD_MEM;
        else if (wb.reg_write && (wb.dest != 5'd0) && (wb.dest == src))
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_stall_counter16.sv
// Saturating 16-bit count of load-use stall cycles.
module stall_counter16 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n)
            r_count <= 16'd0;
        else if (i_inc && (r_count != 16'hFFFF))
            r_count <= r_count + 16'd1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding and one-cycle load-use stall generation.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_dest,
    input  logic        ex_regWrite,
    input  logic        ex_memRead,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic        stall,
    output logic        idex_bubble,
    output logic [15:0] stall_count
);

    stage_t    r_mem;
    stage_t    r_wb;
    hz_state_t r_state;
    hz_state_t w_state_nxt;
    logic      w_hazard;

    // Two-stage shift mirroring EX/MEM and MEM/WB.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_mem.dest      <= ex_dest;
            r_mem.reg_write <= ex_regWrite;
            r_mem.mem_read  <= ex_memRead;
            r_wb.dest       <= r_mem.dest;
            r_wb.reg_write  <= r_mem.reg_write;
            r_wb.mem_read   <= 1'b0;
        end
    end

    assign forwardA = fwd_sel(r_mem, r_wb, ex_rs);
    assign forwardB = fwd_sel(r_mem, r_wb, ex_rt);

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_RUN;
        else
            r_state <= w_state_nxt;
    end

    // In BUBBLE the EX slot holds the inserted nop, so no new hazard.
    always_comb begin
        w_state_nxt = r_state;
        w_hazard    = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_hazard = ex_memRead && (ex_dest != 5'd0) &&
                           ((ex_dest == id_rs) || (ex_dest == id_rt));
                if (w_hazard)
                    w_state_nxt = ST_BUBBLE;
            end
            ST_BUBBLE: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign stall       = w_hazard;
    assign idex_bubble = w_hazard;

    stall_counter16 u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_inc   (w_hazard),
        .o_count (stall_count)
    );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: driver pushes model expectations, monitor compares.
module tb_hazard_forward_unit;

    logic        clock;
    logic        reset_n;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_regWrite;
    logic        ex_memRead;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [1:0]  forwardA;
    logic [1:0]  forwardB;
    logic        stall;
    logic        idex_bubble;
    logic [15:0] stall_count;

    hazard_forward_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ex_rs       (ex_rs),
        .ex_rt       (ex_rt),
        .ex_dest     (ex_dest),
        .ex_regWrite (ex_regWrite),
        .ex_memRead  (ex_memRead),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .forwardA    (forwardA),
        .forwardB    (forwardB),
        .stall       (stall),
        .idex_bubble (idex_bubble),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          id;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        int dest;
        bit rw;
    } wr_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issued = 0;
    bit   drv_done = 0;

    // Reference model: list of older EX entries, newest first.
    wr_t  m_hist[$];
    bit   m_prev_stall;
    int   m_count;

    function automatic void model_clear();
        wr_t z;
        z.dest = 0;
        z.rw   = 0;
        m_hist = {};
        m_hist.push_back(z);
        m_hist.push_back(z);
        m_prev_stall = 0;
        m_count      = 0;
    endfunction

    function automatic int model_fwd(int src);
        if (m_hist[0].rw && m_hist[0].dest != 0 && m_hist[0].dest == src)
            return 2;
        if (m_hist[1].rw && m_hist[1].dest != 0 && m_hist[1].dest == src)
            return 1;
        return 0;
    endfunction

    task automatic drive(input bit rst_n, input int rs, input int rt,
                         input int dest, input bit rw, input bit mr,
                         input int irs, input int irt);
        exp_t e;
        wr_t  w;
        bit   hz;
        @(posedge clock);
        #1;
        reset_n     = rst_n;
        ex_rs       = rs[4:0];
        ex_rt       = rt[4:0];
        ex_dest     = dest[4:0];
        ex_regWrite = rw;
        ex_memRead  = mr;
        id_rs       = irs[4:0];
        id_rt       = irt[4:0];
        if (!rst_n) model_clear();
        hz = !m_prev_stall && mr && dest != 0 && (dest == irs || dest == irt);
        e.id  = n_issued;
        e.fa  = 2'(model_fwd(rs));
        e.fb  = 2'(model_fwd(rt));
        e.st  = hz;
        e.cnt = 16'(m_count);
        exp_q.push_back(e);
        n_issued++;
        if (rst_n) begin
            w.dest = dest;
            w.rw   = rw;
            m_hist.push_front(w);
            void'(m_hist.pop_back());
            m_prev_stall = hz;
            if (hz && m_count < 65535) m_count++;
        end
    endtask

    task automatic chk(input string nm, input int id,
                       input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, required %0h", nm, id, act, req);
        end
    endtask

    // Monitor: samples combinational outputs mid-cycle, away from negedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #3;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("forwardA", e.id, int'(forwardA), int'(e.fa));
                chk("forwardB", e.id, int'(forwardB), int'(e.fb));
                chk("stall", e.id, int'(stall), int'(e.st));
                chk("idex_bubble", e.id, int'(idex_bubble), int'(e.st));
                chk("stall_count", e.id, int'(stall_count), int'(e.cnt));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ex_rs = 0; ex_rt = 0; ex_dest = 0;
        ex_regWrite = 0; ex_memRead = 0;
        id_rs = 0; id_rt = 0;
        model_clear();

        // Reset state
        drive(0, 5, 7, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back dependency: MEM then WB forwarding
        drive(1, 0, 0, 5, 1, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 0, 0, 0, 0);

        // Double match on r7, MEM wins; r0 never forwarded
        drive(1, 0, 0, 7, 1, 0, 0, 0);
        drive(1, 0, 0, 7, 1, 0, 0, 0);
        drive(1, 0, 7, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rt, then suppressed in bubble, then clear
        drive(1, 0, 0, 3, 1, 1, 0, 3);
        drive(1, 0, 0, 3, 1, 1, 0, 3);
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        // Hazard on both id sources counts once; r0 load never stalls
        drive(1, 0, 0, 4, 1, 1, 4, 4);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0, 0);

        // Reset while in BUBBLE with mem_dest=9, no clock edge needed
        drive(1, 0, 0, 9, 1, 1, 9, 0);
        drive(0, 9, 9, 0, 0, 0, 0, 0);
        drive(1, 9, 9, 0, 0, 0, 0, 0);

        // Randomized traffic over a narrow register range
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 60) != 0),
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7), $urandom_range(0, 7));
        end

        // Saturation: preload counter near the top, then keep stalling
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #2;
        force dut.u_stall_cnt.r_count = 16'hFFFD;
        #1;
        release dut.u_stall_cnt.r_count;
        m_count = 16'hFFFD;
        for (int i = 0; i < 8; i++)
            drive(1, 0, 0, 6, 1, 1, 6, 6);
        @(posedge clock);
        #3;
        chk("stall_count_sat", n_issued, int'(stall_count), 16'hFFFF);
        drv_done = 1;
    end

    initial begin
        int guard;
        guard = 0;
        wait (drv_done);
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clock);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: driver not done, required done");
        $fatal(1, "timeout");
    end

endmodule
